// File: rtl/fb_fill_controller.sv
// -----------------------------------------------------------------------------
// fb_fill_controller
//
// Rectangle-fill engine and port-A arbiter for the 12-bit frame buffer.
// Software hands over a rectangle and a colour with a one-cycle start; the
// engine clips it to the screen and writes one pixel per cycle in which the
// CPU is not using port A. CPU accesses always own the port.
//
// Ports:
//   clock, reset        memory clock, asynchronous active-high reset
//   cpu_fb_en/cpu_wen   CPU frame-buffer access / write enable
//   cpu_addr/cpu_din    CPU address / write data
//   start, abort        one-cycle fill request / cancel fill in progress
//   rect_x/y/w/h        rectangle origin and size (clipped to the screen)
//   colour              fill colour, sampled with start
//   fb_wea/addra/dina   frame buffer port A
//   busy                fill in progress
//   done                one-cycle completion or abort pulse
//   fill_stalled        engine wanted the port and lost it to the CPU
// -----------------------------------------------------------------------------
module fb_fill_controller #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_fb_en,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rect_x,
  input  logic [6:0]        rect_y,
  input  logic [7:0]        rect_w,
  input  logic [6:0]        rect_h,
  input  logic [DATA_W-1:0] colour,
  output logic              fb_wea,
  output logic [ADDR_W-1:0] fb_addra,
  output logic [DATA_W-1:0] fb_dina,
  output logic              busy,
  output logic              done,
  output logic              fill_stalled
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  state_t              state, state_next;
  logic [7:0]          col;
  logic [6:0]          row;
  logic [7:0]          eff_w;
  logic [6:0]          eff_h;
  logic [ADDR_W-1:0]   row_base;
  logic [DATA_W-1:0]   colour_q;

  // ---------------------------------------------------------------------------
  // Clipping of the requested rectangle, evaluated only when start is taken.
  // avail_w/avail_h are one bit wider than the coordinates so a full-width
  // screen (H_RES = 256) still fits; they are meaningless when the origin is
  // off-screen, which the x_out/y_out terms cover.
  // ---------------------------------------------------------------------------
  logic              x_out, y_out, empty_rect;
  logic [8:0]        avail_w;
  logic [7:0]        avail_h;
  logic [7:0]        clip_w;
  logic [6:0]        clip_h;
  logic [ADDR_W-1:0] row_base_start;

  assign x_out   = ({1'b0, rect_x} >= 9'(H_RES));
  assign y_out   = ({1'b0, rect_y} >= 8'(V_RES));
  assign avail_w = 9'(H_RES) - {1'b0, rect_x};
  assign avail_h = 8'(V_RES) - {1'b0, rect_y};
  assign clip_w  = ({1'b0, rect_w} < avail_w) ? rect_w : avail_w[7:0];
  assign clip_h  = ({1'b0, rect_h} < avail_h) ? rect_h : avail_h[6:0];

  assign empty_rect = x_out || y_out || (clip_w == 8'd0) || (clip_h == 7'd0);

  assign row_base_start = ADDR_W'(rect_y) * H_RES_A + ADDR_W'(rect_x);

  // ---------------------------------------------------------------------------
  // Fill progress
  // ---------------------------------------------------------------------------
  logic engine_write;
  logic last_col, last_row;

  assign engine_write = (state == S_FILL) && !cpu_fb_en;
  assign last_col     = (col == eff_w - 8'd1);
  assign last_row     = (row == eff_h - 7'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      eff_w    <= '0;
      eff_h    <= '0;
      row_base <= '0;
      colour_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        colour_q <= colour;
        eff_w    <= clip_w;
        eff_h    <= clip_h;
        row_base <= row_base_start;
        col      <= '0;
        row      <= '0;
      end else if (engine_write) begin
        // Counters advance only on a cycle in which the pixel really went out.
        if (last_col) begin
          col      <= '0;
          row      <= row + 7'd1;
          row_base <= row_base + H_RES_A;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can leave it unassigned (a latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        // start outranks a simultaneous abort; abort alone is ignored here.
        if (start) state_next = empty_rect ? S_DONE : S_FILL;
      end
      S_FILL: begin
        // The pixel presented in the abort cycle still goes out if the port
        // is free; the write and the exit happen on the same edge.
        if (abort || (engine_write && last_col && last_row)) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Port A mux: CPU first, engine second, otherwise an idle read of cpu_addr.
  // ---------------------------------------------------------------------------
  always_comb begin
    fb_wea   = 1'b0;
    fb_addra = cpu_addr;
    fb_dina  = cpu_din;
    if (cpu_fb_en) begin
      fb_wea = cpu_wen;
    end else if (state == S_FILL) begin
      fb_wea   = 1'b1;
      fb_addra = row_base + ADDR_W'(col);
      fb_dina  = colour_q;
    end
  end

  assign busy         = (state == S_FILL);
  assign done         = (state == S_DONE);
  assign fill_stalled = (state == S_FILL) && cpu_fb_en;

endmodule

// File: tb/tb_fb_fill_controller.sv
// -----------------------------------------------------------------------------
// tb_fb_fill_controller
//
// Self-checking bench for fb_fill_controller. A table of rectangles with their
// expected write counts is run through a common fill task; every expected
// engine write (address, colour) is pushed to a scoreboard queue when the fill
// is started and popped as the DUT presents it on port A. Hand-written
// sequences cover CPU contention, ignored restart, abort and async reset.
// -----------------------------------------------------------------------------
module tb_fb_fill_controller;

  localparam int H_RES  = 160;
  localparam int V_RES  = 120;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int BUDGET = 20000;

  logic              clock;
  logic              reset;
  logic              cpu_fb_en;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              start;
  logic              abort;
  logic [7:0]        rect_x;
  logic [6:0]        rect_y;
  logic [7:0]        rect_w;
  logic [6:0]        rect_h;
  logic [DATA_W-1:0] colour;
  logic              fb_wea;
  logic [ADDR_W-1:0] fb_addra;
  logic [DATA_W-1:0] fb_dina;
  logic              busy;
  logic              done;
  logic              fill_stalled;

  fb_fill_controller #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_fb_en   (cpu_fb_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .start       (start),
    .abort       (abort),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .colour      (colour),
    .fb_wea      (fb_wea),
    .fb_addra    (fb_addra),
    .fb_dina     (fb_dina),
    .busy        (busy),
    .done        (done),
    .fill_stalled(fill_stalled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected engine writes.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];

  // Reference model: clip the rectangle and list the pixels in raster order.
  task automatic push_expected(input int x, input int y, input int w, input int h,
                               input logic [DATA_W-1:0] c);
    int ew, eh;
    wr_t e;
    ew = (x >= H_RES) ? 0 : ((w < H_RES - x) ? w : H_RES - x);
    eh = (y >= V_RES) ? 0 : ((h < V_RES - y) ? h : V_RES - y);
    for (int r = 0; r < eh; r++) begin
      for (int cc = 0; cc < ew; cc++) begin
        e.addr = ADDR_W'((y + r) * H_RES + x + cc);
        e.data = c;
        sb.push_back(e);
      end
    end
  endtask

  // Runs one fill. Cycle k = 1 is the cycle after the start edge.
  // stall_a/stall_b: cycles in which the CPU writes 0x0AB to 0x0100.
  // abort_at: cycle to raise abort (0 = together with start, -1 = never).
  // restart_at: cycle in which a second, different start is offered.
  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input logic [DATA_W-1:0] c,
                          input int stall_a, input int stall_b,
                          input int abort_at, input int restart_at,
                          output int done_cyc, output int writes,
                          output int busy_cyc, output int stalls);
    wr_t e;
    int  k;
    done_cyc = -1;
    writes   = 0;
    busy_cyc = 0;
    stalls   = 0;

    rect_x = 8'(x);
    rect_y = 7'(y);
    rect_w = 8'(w);
    rect_h = 7'(h);
    colour = c;
    start  = 1'b1;
    abort  = (abort_at == 0);
    @(negedge clock);
    check("idle_no_write", {31'd0, fb_wea}, 32'd0);
    @(posedge clock);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    // Latched inputs may now change freely.
    rect_x = 8'd1;
    rect_y = 7'd1;
    rect_w = 8'd200;
    rect_h = 7'd100;
    colour = 12'hABC;

    k = 0;
    while (k < BUDGET && done_cyc < 0) begin
      k++;
      cpu_fb_en = (k == stall_a) || (k == stall_b);
      cpu_wen   = cpu_fb_en;
      cpu_addr  = cpu_fb_en ? 15'h0100 : 15'h1234;
      cpu_din   = cpu_fb_en ? 12'h0AB : 12'h555;
      abort     = (k == abort_at);
      start     = (k == restart_at);
      @(negedge clock);
      if (busy === 1'b1) busy_cyc++;
      if (fill_stalled === 1'b1) stalls++;
      if (done === 1'b1) done_cyc = k;
      if (cpu_fb_en) begin
        check("cpu_pass_wea", {31'd0, fb_wea}, 32'd1);
        check("cpu_pass_addr", 32'(fb_addra), 32'h0100);
        check("cpu_pass_din", 32'(fb_dina), 32'h0AB);
      end else if (fb_wea !== 1'b0) begin
        writes++;
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(fb_addra), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          check("write_addr_data", {5'd0, fb_addra, fb_dina}, {5'd0, e.addr, e.data});
        end
      end
      @(posedge clock);
      #1;
    end
    cpu_fb_en = 1'b0;
    cpu_wen   = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    // done must be a single-cycle pulse.
    @(negedge clock);
    check("done_one_cycle", {30'd0, done, busy}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int                x, y, w, h;
    logic [DATA_W-1:0] c;
    int                exp_writes;
  } vec_t;

  vec_t vecs[8];

  int done_cyc, writes, busy_cyc, stalls, done_pulses;

  initial begin
    vecs[0] = '{x: 10,  y: 5,   w: 3,   h: 2,   c: 12'hF00, exp_writes: 6};
    vecs[1] = '{x: 158, y: 119, w: 10,  h: 10,  c: 12'h0F0, exp_writes: 2};
    vecs[2] = '{x: 200, y: 0,   w: 5,   h: 5,   c: 12'h00F, exp_writes: 0};
    vecs[3] = '{x: 0,   y: 120, w: 5,   h: 5,   c: 12'h00F, exp_writes: 0};
    vecs[4] = '{x: 20,  y: 20,  w: 0,   h: 4,   c: 12'h123, exp_writes: 0};
    vecs[5] = '{x: 20,  y: 20,  w: 4,   h: 0,   c: 12'h123, exp_writes: 0};
    vecs[6] = '{x: 159, y: 0,   w: 1,   h: 3,   c: 12'h456, exp_writes: 3};
    vecs[7] = '{x: 0,   y: 0,   w: 160, h: 120, c: 12'h000, exp_writes: 19200};

    reset     = 1'b1;
    cpu_fb_en = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = 15'h2A5A;
    cpu_din   = 12'h3C3;
    start     = 1'b0;
    abort     = 1'b0;
    rect_x    = '0;
    rect_y    = '0;
    rect_w    = '0;
    rect_h    = '0;
    colour    = '0;
    #12;
    check("reset_outputs", {29'd0, busy, done, fill_stalled}, 32'd0);
    check("reset_wea", {31'd0, fb_wea}, 32'd0);
    check("reset_idle_addr", 32'(fb_addra), 32'h2A5A);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Table-driven rectangles.
    foreach (vecs[i]) begin
      push_expected(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c);
      run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, -1, -1, -1, -1,
               done_cyc, writes, busy_cyc, stalls);
      check($sformatf("vec%0d_writes", i), 32'(writes), 32'(vecs[i].exp_writes));
      check($sformatf("vec%0d_done_cycle", i), 32'(done_cyc), 32'(vecs[i].exp_writes + 1));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cyc), 32'(vecs[i].exp_writes));
      check($sformatf("vec%0d_sb_empty", i), 32'(sb.size()), 32'd0);
    end

    // CPU contention on fill cycles 2 and 4 of the small box.
    push_expected(10, 5, 3, 2, 12'hF00);
    run_fill(10, 5, 3, 2, 12'hF00, 2, 4, -1, -1, done_cyc, writes, busy_cyc, stalls);
    check("contend_writes", 32'(writes), 32'd6);
    check("contend_done_cycle", 32'(done_cyc), 32'd9);
    check("contend_stalls", 32'(stalls), 32'd2);
    check("contend_busy_cycles", 32'(busy_cyc), 32'd8);
    check("contend_sb_empty", 32'(sb.size()), 32'd0);

    // A second start while busy is ignored.
    push_expected(30, 7, 4, 2, 12'h0C0);
    run_fill(30, 7, 4, 2, 12'h0C0, -1, -1, -1, 3, done_cyc, writes, busy_cyc, stalls);
    check("restart_writes", 32'(writes), 32'd8);
    check("restart_done_cycle", 32'(done_cyc), 32'd9);
    check("restart_sb_empty", 32'(sb.size()), 32'd0);

    // Start and abort together in IDLE: start wins.
    push_expected(10, 5, 3, 2, 12'hF00);
    run_fill(10, 5, 3, 2, 12'hF00, -1, -1, 0, -1, done_cyc, writes, busy_cyc, stalls);
    check("start_abort_writes", 32'(writes), 32'd6);
    check("start_abort_done_cycle", 32'(done_cyc), 32'd7);

    // Abort a full-screen fill on its 50th busy cycle.
    push_expected(0, 0, 160, 120, 12'h777);
    run_fill(0, 0, 160, 120, 12'h777, -1, -1, 50, -1, done_cyc, writes, busy_cyc, stalls);
    check("abort_writes", 32'(writes), 32'd50);
    check("abort_done_cycle", 32'(done_cyc), 32'd51);
    check("abort_sb_left", 32'(sb.size()), 32'(19200 - 50));
    sb.delete();

    // A new start is accepted after the abort.
    push_expected(10, 5, 3, 2, 12'hF00);
    run_fill(10, 5, 3, 2, 12'hF00, -1, -1, -1, -1, done_cyc, writes, busy_cyc, stalls);
    check("post_abort_writes", 32'(writes), 32'd6);
    check("post_abort_done_cycle", 32'(done_cyc), 32'd7);

    // Asynchronous reset in the middle of a fill.
    rect_x = 8'd10;
    rect_y = 7'd5;
    rect_w = 8'd3;
    rect_h = 7'd2;
    colour = 12'hF00;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #3;
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_busy", {31'd0, busy}, 32'd0);
    check("reset_mid_wea", {31'd0, fb_wea}, 32'd0);
    #1;
    reset = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) done_pulses++;
    end
    check("reset_mid_no_done", 32'(done_pulses), 32'd0);
    @(posedge clock);
    #1;

    push_expected(10, 5, 3, 2, 12'hF00);
    run_fill(10, 5, 3, 2, 12'hF00, -1, -1, -1, -1, done_cyc, writes, busy_cyc, stalls);
    check("post_reset_writes", 32'(writes), 32'd6);
    check("post_reset_done_cycle", 32'(done_cyc), 32'd7);
    check("post_reset_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
